// File: rtl/tempo_step_clock.sv
// tempo_step_clock
//   Turns an 8-bit BPM value into the sequencer timebase. A phase accumulator
//   adds bpm*SUBDIV every clock and emits a step when it crosses CLK_HZ*60.
//   This keeps the long-run step rate exact without needing a divider.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   bpm        tempo in beats per minute
//   run        level: 1 = play, 0 = pause
//   restart    one-cycle pulse that returns playback to step 0
//   step_tick  one-cycle pulse per step
//   step_idx   current step, 0..STEPS-1 (already updated during a tick)
//   beat_tick  step_tick on steps where step_idx % SUBDIV == 0
//   bar_tick   step_tick on step 0
//   beat_led   beat_tick stretched to BLINK_CYC cycles
//   playing    high in ARM or RUN
module tempo_step_clock #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned SUBDIV    = 4,
  parameter int unsigned STEPS     = 16,
  parameter int          STEP_W    = 4,
  parameter int          ACC_W     = 32,
  parameter int unsigned BLINK_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        bpm,
  input  logic              run,
  input  logic              restart,
  output logic              step_tick,
  output logic [STEP_W-1:0] step_idx,
  output logic              beat_tick,
  output logic              bar_tick,
  output logic              beat_led,
  output logic              playing
);

  localparam logic [ACC_W-1:0] THRESH = ACC_W'(64'(CLK_HZ) * 64'd60);
  localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [7:0]          r_bpm_q;
  logic [STEP_W-1:0]   r_step_idx;
  logic                r_step_tick;
  logic                r_beat_tick;
  logic                r_bar_tick;
  logic                r_beat_led;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_playing;

  logic [ACC_W-1:0]    w_inc;
  logic [ACC_W-1:0]    w_sum;
  logic [STEP_W-1:0]   w_next_idx;
  logic                w_on_beat;

  always_comb begin
    w_inc      = ACC_W'(r_bpm_q) * ACC_W'(SUBDIV);
    w_sum      = r_acc + w_inc;
    w_next_idx = (r_step_idx == STEP_W'(STEPS - 1)) ? '0 : r_step_idx + 1'b1;
    w_on_beat  = ((32'(w_next_idx) % SUBDIV) == 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_bpm_q     <= '0;
      r_step_idx  <= '0;
      r_step_tick <= 1'b0;
      r_beat_tick <= 1'b0;
      r_bar_tick  <= 1'b0;
      r_beat_led  <= 1'b0;
      r_blink_cnt <= '0;
      r_playing   <= 1'b0;
    end else begin
      r_step_tick <= 1'b0;
      r_beat_tick <= 1'b0;
      r_bar_tick  <= 1'b0;
      // LED stays lit through the cycle in which the counter reaches zero,
      // giving BLINK_CYC high cycles counting the load cycle.
      if (r_blink_cnt != '0) begin
        r_blink_cnt <= r_blink_cnt - 1'b1;
      end
      r_beat_led <= (r_blink_cnt != '0);

      case (r_state)
        S_IDLE: begin
          r_acc       <= '0;
          r_step_idx  <= '0;
          r_blink_cnt <= '0;
          r_beat_led  <= 1'b0;
          if (!restart && run) begin
            r_state   <= S_ARM;
            r_playing <= 1'b1;
          end else begin
            r_playing <= 1'b0;
          end
        end

        S_ARM: begin
          if (restart && !run) begin
            r_state     <= S_IDLE;
            r_playing   <= 1'b0;
            r_acc       <= '0;
            r_step_idx  <= '0;
            r_blink_cnt <= '0;
            r_beat_led  <= 1'b0;
          end else begin
            r_bpm_q     <= bpm;
            r_acc       <= '0;
            r_step_idx  <= '0;
            r_step_tick <= 1'b1;
            r_beat_tick <= 1'b1;
            r_bar_tick  <= 1'b1;
            r_beat_led  <= 1'b1;
            r_blink_cnt <= BLINK_LOAD;
            r_state     <= restart ? S_ARM : S_RUN;
          end
        end

        S_RUN: begin
          if (restart) begin
            if (run) begin
              r_state <= S_ARM;
            end else begin
              r_state     <= S_IDLE;
              r_playing   <= 1'b0;
              r_acc       <= '0;
              r_step_idx  <= '0;
              r_blink_cnt <= '0;
              r_beat_led  <= 1'b0;
            end
          end else if (!run) begin
            // Phase is frozen from the cycle run=0 is sampled.
            r_state   <= S_PAUSE;
            r_playing <= 1'b0;
          end else if (w_sum >= THRESH) begin
            r_acc       <= w_sum - THRESH;
            r_step_idx  <= w_next_idx;
            r_step_tick <= 1'b1;
            r_beat_tick <= w_on_beat;
            r_bar_tick  <= (w_next_idx == '0);
            // New tempo only takes hold at a step boundary.
            r_bpm_q     <= bpm;
            if (w_on_beat) begin
              r_beat_led  <= 1'b1;
              r_blink_cnt <= BLINK_LOAD;
            end
          end else begin
            r_acc <= w_sum;
          end
        end

        S_PAUSE: begin
          if (restart) begin
            r_state     <= S_IDLE;
            r_playing   <= 1'b0;
            r_acc       <= '0;
            r_step_idx  <= '0;
            r_blink_cnt <= '0;
            r_beat_led  <= 1'b0;
          end else if (run) begin
            r_state   <= S_RUN;
            r_playing <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign step_tick = r_step_tick;
  assign step_idx  = r_step_idx;
  assign beat_tick = r_beat_tick;
  assign bar_tick  = r_bar_tick;
  assign beat_led  = r_beat_led;
  assign playing   = r_playing;

endmodule
